// File: rtl/band_gain_interp_pkg.sv
// Shared constants, band table and types for the band-to-bin gain interpolator.
package band_gain_pkg;

    localparam int GAIN_W      = 16;
    localparam int NB_BANDS    = 22;
    localparam int FREQ_SIZE   = 481;
    localparam int FRAME_SHIFT = 2;     // band edges are in units of 4 bins
    localparam int BIN_W       = 9;

    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GAIN_ONE = 16'h8000;  // 1.0 in Q1.15

    localparam int EBAND [0:NB_BANDS-1] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100
    };

    // round(65536 / band_size) per band, Q0.16
    localparam logic [15:0] RECIP [0:NB_BANDS-2] = '{
        16'd16384, 16'd16384, 16'd16384, 16'd16384,
        16'd16384, 16'd16384, 16'd16384, 16'd16384,
        16'd8192,  16'd8192,  16'd8192,  16'd8192,
        16'd4096,  16'd4096,  16'd4096,
        16'd2731,  16'd2731,  16'd2048,  16'd1365,
        16'd910,   16'd745
    };

    // first bin past the last band edge; bins from here on are zero-filled
    localparam int BAND_END = EBAND[NB_BANDS-1] << FRAME_SHIFT;

    typedef enum logic {IDLE, RUN} state_t;

    // number of bins covered by band i (0 for the out-of-range index)
    function automatic logic [6:0] band_size(input logic [4:0] i);
        if (int'(i) >= NB_BANDS - 1) return '0;
        return 7'((EBAND[int'(i) + 1] - EBAND[int'(i)]) << FRAME_SHIFT);
    endfunction

endpackage

// File: rtl/band_gain_interp_if.sv
// Frame-in / bin-stream-out handshake bundle for band_gain_interp.
interface band_gain_interp_if;
    import band_gain_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [NB_BANDS*GAIN_W-1:0]  in_gains;
    logic                        out_valid;
    logic                        out_ready;
    gain_t                       out_gain;
    logic [BIN_W-1:0]            out_bin;
    logic                        out_last;

    modport slave (
        input  in_valid, in_gains, out_ready,
        output in_ready, out_valid, out_gain, out_bin, out_last
    );

    modport master (
        output in_valid, in_gains, out_ready,
        input  in_ready, out_valid, out_gain, out_bin, out_last
    );

endinterface

// File: rtl/band_gain_interp_lerp.sv
// Combinational linear interpolation a + floor((b-a)*frac / 2^16),
// saturated to [0, 1.0] in Q1.15.
module gain_lerp
    import band_gain_pkg::*;
(
    input  gain_t       a,
    input  gain_t       b,
    input  logic [15:0] frac,
    output gain_t       y
);

    logic signed [16:0] d;
    logic signed [33:0] prod;
    logic signed [17:0] delta;
    logic signed [18:0] sum;

    assign d     = signed'({1'b0, b}) - signed'({1'b0, a});
    assign prod  = d * signed'({1'b0, frac});
    // arithmetic shift gives floor rounding for negative slopes
    assign delta = 18'(prod >>> 16);
    assign sum   = 19'(signed'({1'b0, a})) + 19'(delta);

    // saturate to [0, GAIN_ONE]
    always_comb begin
        y = sum[15:0];
        if (sum[18])
            y = '0;
        else if (sum > 19'sd32768)
            y = GAIN_ONE;
    end

endmodule

// File: rtl/band_gain_interp.sv
// Expands 22 per-band gains into 481 per-bin gains, one bin per cycle.
// Optional gain floor: define GAIN_INTERP_FLOOR_EN to clamp every bin to MIN_GAIN.
module band_gain_interp
    import band_gain_pkg::*;
#(
    parameter gain_t MIN_GAIN = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    band_gain_interp_if.slave bus
);

`ifdef GAIN_INTERP_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    state_t            state, state_nxt;
    gain_t             frame [NB_BANDS];
    logic [4:0]        band;
    logic [6:0]        j;
    logic [BIN_W-1:0]  bin;
    logic              in_ready, accept, load, in_band;
    logic [15:0]       recip, frac;
    gain_t             ga, gb, lerp_y, zfill, gain_nxt;
    logic              out_valid, out_last;
    gain_t             out_gain;
    logic [BIN_W-1:0]  out_bin;

    assign accept  = in_ready && bus.in_valid;
    assign in_band = int'(bin) < BAND_END;
    // output register takes a new bin when empty or being drained
    assign load    = (state == RUN) && (int'(bin) < FREQ_SIZE) && (!out_valid || bus.out_ready);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; ready only while idle and out of reset
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept) state_nxt = RUN;
            end
            RUN: if (out_valid && bus.out_ready && out_last) state_nxt = IDLE;
        endcase
    end

    // capture the whole frame so upstream is free once accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB_BANDS; k++) frame[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NB_BANDS; k++) frame[k] <= bus.in_gains[k*GAIN_W +: GAIN_W];
        end
    end

    // operand selection; band+1 is only read inside the interpolated range
    always_comb begin
        ga    = frame[band];
        gb    = '0;
        recip = '0;
        if (in_band) begin
            gb    = frame[band + 5'd1];
            recip = RECIP[band];
        end
        frac = j * recip;
    end

    gain_lerp u_lerp (
        .a    (ga),
        .b    (gb),
        .frac (frac),
        .y    (lerp_y)
    );

    // zero-fill past the last band, then optional floor
    always_comb begin
        zfill    = in_band ? lerp_y : '0;
        gain_nxt = (FLOOR_EN && (zfill < MIN_GAIN)) ? MIN_GAIN : zfill;
    end

    // band / in-band offset / bin counters, advanced only on output load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band <= '0;
            j    <= '0;
            bin  <= '0;
        end else if (accept) begin
            band <= '0;
            j    <= '0;
            bin  <= '0;
        end else if (load) begin
            bin <= bin + 1'b1;
            if (in_band) begin
                if (j == band_size(band) - 7'd1) begin
                    j    <= '0;
                    band <= band + 5'd1;
                end else begin
                    j <= j + 7'd1;
                end
            end
        end
    end

    // output register; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gain  <= '0;
            out_bin   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_gain  <= gain_nxt;
            out_bin   <= bin;
            out_last  <= (bin == BIN_W'(FREQ_SIZE - 1));
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_gain  = out_gain;
    assign bus.out_bin   = out_bin;
    assign bus.out_last  = out_last;

endmodule
